id_stage: RTL and testbench

- Decode stage of the 5-stage ARM pipeline, directly downstream of the fetch stage's IF/ID register.
- Consumes the latched PC and instruction, and holds the architectural register file R0–R14.
- Decodes the control signals and evaluates the instruction's condition field against the NZCV status.
- Registers all results into the ID/EX pipeline register.
- Exposes combinational source-register info to the hazard unit.

---
 rtl/id_stage.sv | 131 +++++++++++++
 tb/tb_id_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: ARM decode stage with register file, condition check and ID/EX register.
// Define REGFILE_BYPASS_EN to make same-cycle writebacks visible to the operand reads.
module id_stage #(
    parameter int REG_COUNT = 15,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hazard,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] Instruction_in,
    input  logic [3:0]       Status,
    input  logic             WB_EN_in,
    input  logic [3:0]       WB_Dest,
    input  logic [WIDTH-1:0] WB_Value,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Val_Rn,
    output logic [WIDTH-1:0] Val_Rm,
    output logic             Imm,
    output logic [11:0]      Shift_operand,
    output logic [23:0]      Signed_imm_24,
    output logic [3:0]       Dest,
    output logic [3:0]       EXE_CMD,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             WB_EN,
    output logic             B,
    output logic             S,
    output logic [3:0]       src1,
    output logic [3:0]       src2,
    output logic             Two_src
);
    localparam int IW = 3 * WIDTH + 50;
    logic [WIDTH-1:0] regs [REG_COUNT];
    logic [WIDTH-1:0] rn_val, rm_val;
    logic [IW-1:0] idex_q;
    logic [3:0] rn, rm, opcode, cond, exe;
    logic [1:0] mode;
    logic s_in, wr, store, cond_ok, mr, mw, wb, br, s_bit, ctl_ok;
    assign cond   = Instruction_in[31:28];
    assign mode   = Instruction_in[27:26];
    assign opcode = Instruction_in[24:21];
    assign s_in   = Instruction_in[20];
    assign rn     = Instruction_in[19:16];
    assign rm     = Instruction_in[3:0];
    assign wr     = WB_EN_in && (int'(WB_Dest) < REG_COUNT);
`ifdef REGFILE_BYPASS_EN
    assign rn_val = rn == 4'hf ? PC_in : (wr && WB_Dest == rn) ? WB_Value : regs[rn];
    assign rm_val = rm == 4'hf ? PC_in : (wr && WB_Dest == rm) ? WB_Value : regs[rm];
`else
    assign rn_val = rn == 4'hf ? PC_in : regs[rn];
    assign rm_val = rm == 4'hf ? PC_in : regs[rm];
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) for (int i = 0; i < REG_COUNT; i++) regs[i] <= WIDTH'(i);
        else if (wr) regs[WB_Dest] <= WB_Value;
    end
    // A zero ALU command doubles as the marker for unsupported data-processing opcodes
    always_comb begin
        exe = 4'd0;
        mr = 1'b0;
        mw = 1'b0;
        wb = 1'b0;
        br = 1'b0;
        s_bit = 1'b0;
        case (mode)
            2'b00: begin
                case (opcode)
                    4'b1101: exe = 4'b0001;
                    4'b1111: exe = 4'b1001;
                    4'b0100: exe = 4'b0010;
                    4'b0101: exe = 4'b0011;
                    4'b0010: exe = 4'b0100;
                    4'b0110: exe = 4'b0101;
                    4'b0000: exe = 4'b0110;
                    4'b1100: exe = 4'b0111;
                    4'b0001: exe = 4'b1000;
                    4'b1010: exe = 4'b0100;
                    4'b1000: exe = 4'b0110;
                    default: exe = 4'b0000;
                endcase
                wb = exe != 4'd0 && opcode != 4'b1010 && opcode != 4'b1000;
                s_bit = exe != 4'd0 && s_in;
            end
            2'b01: begin
                exe = 4'b0010;
                mr = s_in;
                mw = !s_in;
                wb = s_in;
                s_bit = s_in;
            end
            2'b10: br = 1'b1;
            default: ;
        endcase
    end
    always_comb begin
        case (cond)
            4'h0: cond_ok = Status[2];
            4'h1: cond_ok = !Status[2];
            4'h2: cond_ok = Status[1];
            4'h3: cond_ok = !Status[1];
            4'h4: cond_ok = Status[3];
            4'h5: cond_ok = !Status[3];
            4'h6: cond_ok = Status[0];
            4'h7: cond_ok = !Status[0];
            4'h8: cond_ok = Status[1] && !Status[2];
            4'h9: cond_ok = !Status[1] || Status[2];
            4'ha: cond_ok = Status[3] == Status[0];
            4'hb: cond_ok = Status[3] != Status[0];
            4'hc: cond_ok = !Status[2] && (Status[3] == Status[0]);
            4'hd: cond_ok = Status[2] || (Status[3] != Status[0]);
            4'he: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
    assign ctl_ok  = cond_ok && !hazard;
    assign store   = mode == 2'b01 && !s_in;
    assign src1    = rn;
    assign src2    = store ? Instruction_in[15:12] : rm;
    assign Two_src = (mode == 2'b00 && !Instruction_in[25]) || store;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else if (flush) idex_q <= '0;
        else idex_q <= {PC_in, rn_val, rm_val, Instruction_in[25], Instruction_in[11:0],
                        Instruction_in[23:0], Instruction_in[15:12],
                        ctl_ok ? {exe, mr, mw, wb, br, s_bit} : 9'd0};
    end
    assign {PC, Val_Rn, Val_Rm, Imm, Shift_operand, Signed_imm_24, Dest, EXE_CMD,
            MEM_R_EN, MEM_W_EN, WB_EN, B, S} = idex_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage with a table-driven reference model checked every cycle.
module tb_id_stage;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] pc, rn, rm;
        logic imm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0] dest, cmd;
        logic mr, mw, wb, b, s;
    } idex_t;
    logic clk = 1'b0, rst, flush, hazard, wb_en_in;
    logic [31:0] pc_in, instr, wb_value;
    logic [3:0] status, wb_dest;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic Imm, MEM_R_EN, MEM_W_EN, WB_EN, B, S, Two_src;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0] Dest, EXE_CMD, src1, src2;
    idex_t got, exp_q = '0;
    logic [31:0] mregs [15];
    logic [3:0] alu_tab [16] = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                                 4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};
    logic [3:0] flags [8] = '{4'h0, 4'h4, 4'h8, 4'h1, 4'h2, 4'h6, 4'h9, 4'hf};
    int checks = 0, errors = 0;
    bit started = 1'b0;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .hazard(hazard), .PC_in(pc_in),
        .Instruction_in(instr), .Status(status), .WB_EN_in(wb_en_in), .WB_Dest(wb_dest),
        .WB_Value(wb_value), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Imm(Imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
        .EXE_CMD(EXE_CMD), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
        .B(B), .S(S), .src1(src1), .src2(src2), .Two_src(Two_src)
    );

    always #5 clk = ~clk;
    assign got = {PC, Val_Rn, Val_Rm, Imm, Shift_operand, Signed_imm_24, Dest, EXE_CMD,
                  MEM_R_EN, MEM_W_EN, WB_EN, B, S};

    initial for (int i = 0; i < 15; i++) mregs[i] = i;

    task automatic check(string name, logic [159:0] act, logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic cond_pass(logic [3:0] c, logic [3:0] f);
        logic n = f[3], z = f[2], cy = f[1], v = f[0];
        logic r;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & !z;
            3'd5: r = n == v;
            3'd6: r = !z & (n == v);
            default: r = 1'b1;
        endcase
        return c == 4'hf ? 1'b0 : (c[0] ? !r : r);
    endfunction

    function automatic logic [31:0] rdreg(logic [3:0] idx);
        if (idx == 4'hf) return pc_in;
        if (BYP && wb_en_in && wb_dest == idx) return wb_value;
        return mregs[idx];
    endfunction

    function automatic idex_t predict(logic [31:0] ins);
        idex_t e = '0;
        logic [1:0] md = ins[27:26];
        logic sb = ins[20];
        logic [3:0] opc = ins[24:21];
        e.pc = pc_in;
        e.rn = rdreg(ins[19:16]);
        e.rm = rdreg(ins[3:0]);
        e.imm = ins[25];
        e.sh = ins[11:0];
        e.si = ins[23:0];
        e.dest = ins[15:12];
        if (md == 2'd0 && alu_tab[opc] != 4'd0) begin
            e.cmd = alu_tab[opc];
            e.wb = !(opc inside {4'h8, 4'ha});
            e.s = sb;
        end else if (md == 2'd1) begin
            e.cmd = 4'h2;
            e.mr = sb;
            e.wb = sb;
            e.mw = !sb;
            e.s = sb;
        end else if (md == 2'd2) e.b = 1'b1;
        if (hazard || !cond_pass(ins[31:28], status))
            {e.cmd, e.mr, e.mw, e.wb, e.b, e.s} = '0;
        return e;
    endfunction

    // Reference model: next ID/EX contents from pre-edge inputs, then the regfile write
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q = '0;
            for (int i = 0; i < 15; i++) mregs[i] = i;
        end else begin
            exp_q = flush ? '0 : predict(instr);
            if (wb_en_in && wb_dest != 4'hf) mregs[wb_dest] = wb_value;
        end
    end

    always @(negedge clk) if (started) begin
        check("idex", 160'(got), 160'(exp_q));
        check("src1", 160'(src1), 160'(instr[19:16]));
        check("src2", 160'(src2), 160'((instr[27:26] == 2'd1 && !instr[20]) ? instr[15:12] : instr[3:0]));
        check("two_src", 160'(Two_src), 160'((instr[27:26] == 2'd0 && !instr[25]) || (instr[27:26] == 2'd1 && !instr[20])));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hazard = 1'b0; wb_en_in = 1'b0;
        pc_in = 32'h0; instr = 32'h0; status = 4'h0; wb_dest = 4'h0; wb_value = 32'h0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        started = 1'b1;
        #1 check("reset_pc", 160'(PC), 160'(0));
        check("reset_ctl", 160'({EXE_CMD, WB_EN, B}), 160'(0));
        pc_in = 32'h104; instr = 32'he0812003;
        tick();
        check("add_rn", 160'(Val_Rn), 160'(1));
        check("add_rm", 160'(Val_Rm), 160'(3));
        check("add_dest", 160'(Dest), 160'(2));
        check("add_cmd", 160'(EXE_CMD), 160'(4'b0010));
        check("add_wb", 160'(WB_EN), 160'(1));
        check("add_two", 160'(Two_src), 160'(1));
        check("add_pc", 160'(PC), 160'(32'h104));
        pc_in = 32'h108; instr = 32'h03a00005;
        tick();
        check("moveq_fail", 160'({EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, B, S}), 160'(0));
        status = 4'b0100;
        tick();
        check("moveq_cmd", 160'(EXE_CMD), 160'(4'b0001));
        check("moveq_wb", 160'(WB_EN), 160'(1));
        check("moveq_imm", 160'(Imm), 160'(1));
        check("moveq_sh", 160'(Shift_operand), 160'(12'h005));
        status = 4'h0; pc_in = 32'h10c; instr = 32'he5814008;
        tick();
        check("str_src2", 160'(src2), 160'(4));
        check("str_two", 160'(Two_src), 160'(1));
        check("str_mw", 160'(MEM_W_EN), 160'(1));
        check("str_wb", 160'(WB_EN), 160'(0));
        instr = 32'he5914008;
        tick();
        check("ldr_mr", 160'(MEM_R_EN), 160'(1));
        check("ldr_wb", 160'(WB_EN), 160'(1));
        instr = 32'he0812003; wb_en_in = 1'b1; wb_dest = 4'd1; wb_value = 32'hdeadbeef;
        tick();
        check("wb_same", 160'(Val_Rn), 160'(BYP ? 32'hdeadbeef : 32'd1));
        wb_en_in = 1'b0;
        tick();
        check("wb_next", 160'(Val_Rn), 160'(32'hdeadbeef));
        hazard = 1'b1;
        tick();
        check("haz_data", 160'({Val_Rn, Dest}), 160'({32'hdeadbeef, 4'd2}));
        check("haz_ctl", 160'({EXE_CMD, WB_EN}), 160'(0));
        flush = 1'b1;
        tick();
        check("flush_all", 160'(got), 160'(0));
        flush = 1'b0; hazard = 1'b0; instr = 32'hea000010;
        tick();
        check("b_bit", 160'(B), 160'(1));
        check("b_imm", 160'(Signed_imm_24), 160'(24'h000010));
        check("b_ctl", 160'({EXE_CMD, WB_EN, S}), 160'(0));
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 8; f++) begin
                status = flags[f];
                pc_in = pc_in + 4;
                instr = {c[3:0], (f[0] ? 28'h0912003 : 28'h0812003)};
                tick();
            end
        status = 4'h0;
        for (int o = 0; o < 16; o++) begin
            instr = {4'he, 2'b00, 1'b0, o[3:0], 1'b1, 4'h2, 4'h3, 8'h00, 4'hf};
            wb_en_in = o[0]; wb_dest = o[3:0]; wb_value = 32'h1000 + o;
            tick();
        end
        instr = 32'hec000000; wb_en_in = 1'b1; wb_dest = 4'hf; wb_value = 32'hffff0000;
        tick();
        instr = 32'he0850000; wb_dest = 4'd5; wb_value = 32'h1234;
        tick();
        wb_en_in = 1'b0;
        tick();
        check("r5_written", 160'(Val_Rn), 160'(32'h1234));
        wb_en_in = 1'b1; wb_value = 32'h55;
        #2 rst = 1'b0;
        #1 check("async_rst", 160'(got), 160'(0));
        wb_en_in = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        check("r5_restored", 160'(Val_Rn), 160'(5));
        tick();
        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
